// File: rtl/gpio_filt_pkg.sv
// ============================================================================
// Module   : gpio_filt_pkg
// Brief    : Shared defaults and threshold helper for the GPIO input filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_filt_pkg;

    localparam int GPIO_FILT_NBITS       = 8;
    localparam int GPIO_FILT_CNT_W       = 8;
    localparam int GPIO_FILT_SYNC_STAGES = 2;

    // Threshold is carried at 32 bits so one helper serves every CNT_W (<= 31).
    localparam int GPIO_FILT_T_W = 32;

    // A disabled filter or a zero threshold behaves as a one-cycle threshold.
    function automatic logic [GPIO_FILT_T_W-1:0] eff_thresh(
        input logic                     filt_en,
        input logic [GPIO_FILT_T_W-1:0] thresh
    );
        if (!filt_en || (thresh == '0)) begin
            return GPIO_FILT_T_W'(1);
        end
        return thresh;
    endfunction

endpackage : gpio_filt_pkg

`default_nettype wire

// File: rtl/gpio_filt_bit.sv
// ============================================================================
// Module   : gpio_filt_bit
// Brief    : One GPIO line: synchroniser, debounce counter, filtered flop and
//            optional edge-pulse flops (GPIO_IN_FILTER_EDGE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_filt_bit
    import gpio_filt_pkg::*;
#(
    parameter int CNT_W       = GPIO_FILT_CNT_W,
    parameter int SYNC_STAGES = GPIO_FILT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pad_din,
    input  logic             filt_en,
    input  logic [CNT_W-1:0] thresh,
    output logic             filt_out,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    logic [SYNC_STAGES-1:0]   r_sync;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_filt;
    logic                     w_sync_out;
    logic                     w_diff;
    logic                     w_update;
    logic [GPIO_FILT_T_W-1:0] w_thr;
    logic [GPIO_FILT_T_W-1:0] w_cnt_inc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_din};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Threshold is sampled live, so a lowered value can release a bit whose
    // count already meets it on the very next differing edge.
    assign w_thr     = eff_thresh(filt_en, GPIO_FILT_T_W'(thresh));
    assign w_cnt_inc = GPIO_FILT_T_W'(r_cnt) + GPIO_FILT_T_W'(1);
    assign w_diff    = w_sync_out ^ r_filt;
    assign w_update  = w_diff && (w_cnt_inc >= w_thr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            if (!w_diff || w_update) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_update) begin
                r_filt <= w_sync_out;
            end
        end
    end

    assign filt_out = r_filt;

`ifdef GPIO_IN_FILTER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered alongside the filtered value so they line up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_update &  w_sync_out;
            r_fall <= w_update & ~w_sync_out;
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule : gpio_filt_bit

`default_nettype wire

// File: rtl/gpio_in_filter.sv
// ============================================================================
// Module   : gpio_in_filter
// Brief    : Per-bit synchronise/debounce stage ahead of the GPIO core, with
//            optional edge pulses and masked irq (GPIO_IN_FILTER_EDGE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_in_filter
    import gpio_filt_pkg::*;
#(
    parameter int NBITS       = GPIO_FILT_NBITS,
    parameter int CNT_W       = GPIO_FILT_CNT_W,
    parameter int SYNC_STAGES = GPIO_FILT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NBITS-1:0] pad_din,
    input  logic [NBITS-1:0] filt_en,
    input  logic [CNT_W-1:0] thresh,
    input  logic [NBITS-1:0] irq_mask,
    output logic [NBITS-1:0] gpioi_din,
    output logic [NBITS-1:0] rise_pulse,
    output logic [NBITS-1:0] fall_pulse,
    output logic             irq
);

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        gpio_filt_bit #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk        (clk),
            .rstn       (rstn),
            .pad_din    (pad_din[i]),
            .filt_en    (filt_en[i]),
            .thresh     (thresh),
            .filt_out   (gpioi_din[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

`ifdef GPIO_IN_FILTER_EDGE_EN
    // Built only from registered pulses, so pad activity cannot glitch it.
    assign irq = |((rise_pulse | fall_pulse) & irq_mask);
`else
    logic w_unused_mask;
    assign w_unused_mask = ^irq_mask;
    assign irq           = 1'b0;
`endif

endmodule : gpio_in_filter

`default_nettype wire

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
Input-conditioning stage that sits directly upstream of the GPIO core's din input. It takes raw asynchronous pad samples and, per bit, synchronises them and optionally debounces them against a programmable stability threshold. It drives the clean value to the core's gpioi_din. Optionally it also produces per-bit rise/fall pulses and a masked interrupt request.

Parameters:
NBITS, 8, number of GPIO lines filtered (1..32)
CNT_W, 8, width of debounce counter and threshold
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
pad_din  in  NBITS  raw pad inputs, asynchronous to clk
filt_en  in  NBITS  per-bit debounce enable; 0 = bypass filter
thresh  in  CNT_W  stable cycles required before a filtered bit changes (shared by all bits)
irq_mask  in  NBITS  per-bit interrupt enable
gpioi_din  out  NBITS  filtered/synchronised value to GPIO core
rise_pulse  out  NBITS  one-cycle pulse on 0->1 of gpioi_din bit
fall_pulse  out  NBITS  one-cycle pulse on 1->0 of gpioi_din bit
irq  out  1  OR of (rise_pulse|fall_pulse) & irq_mask

Behaviour:
- Reset: all sync flops, counters, gpioi_din, rise_pulse, fall_pulse and irq clear to 0 immediately on rstn low. No clock is needed.
- Synchroniser: pad_din[i] passes through SYNC_STAGES flops. s[i] is the last stage.
- Effective threshold: T = (filt_en[i] == 0 || thresh == 0) ? 1 : thresh.
- Per-bit counter c[i] (CNT_W bits), evaluated each rising edge:
  - s[i] == gpioi_din[i]: c <= 0.
  - s[i] != gpioi_din[i] and c+1 >= T: gpioi_din[i] <= s[i]; c <= 0.
  - Otherwise: c <= c+1.
- Latency: a pad change stable through capture appears on gpioi_din after SYNC_STAGES+T rising edges. For bypass this is SYNC_STAGES+1.
- Glitch rejection: a difference lasting fewer than T consecutive cycles resets c and leaves gpioi_din unchanged.
- Threshold change mid-count: the comparison uses the current thresh. If c+1 >= new T, the bit updates on the next differing edge.
- The counter never exceeds T-1, so there is no wrap.
- filt_en toggled mid-count: the new T applies immediately, by the same rule.
- Edge pulses: registered in the same edge as the gpioi_din update. A pulse is high for exactly one cycle, concurrent with the new gpioi_din value.
- Back-to-back toggles are impossible within T cycles.
- irq is combinational from the registered pulses and irq_mask, so it is glitch-free with respect to pad.
- After reset release with a pad held at 1, a rise pulse is issued after SYNC_STAGES+T edges. This is intended.

Optional Feature:
Macro: GPIO_IN_FILTER_EDGE_EN
- Defined: rise_pulse, fall_pulse and irq behave as above.
- Undefined: edge registers are not built; rise_pulse, fall_pulse and irq are tied to 0. The ports remain present, and irq_mask is ignored.

Decomposition:
- Package gpio_filt_pkg holds:
  - default constants GPIO_FILT_NBITS, GPIO_FILT_CNT_W, GPIO_FILT_SYNC_STAGES;
  - function eff_thresh(filt_en, thresh) returning T.
- Sub-module gpio_filt_bit holds one bit's sync chain, counter, filtered flop and edge flops.
- The top generates NBITS instances of gpio_filt_bit and ORs the masked pulses into irq.

Test Plan:
1. NBITS=8, filt_en=0x00; pad_din 0x00->0xA5 just after edge N -> gpioi_din=0xA5 after edge N+3; rise_pulse=0xA5 for one cycle only; fall_pulse=0.
2. filt_en=0xFF, thresh=4:
   - pad_din[0] high for 3 cycles, then low -> gpioi_din stays 0x00; no pulses.
   - pad_din[0] then held high -> gpioi_din[0]=1 after edge N+6; rise_pulse[0] high one cycle.
3. filt_en=0xFF, thresh=0 -> latency identical to bypass (3 edges).
4. thresh=10, pad_din[3] differs for 5 cycles, then thresh set to 3 -> gpioi_din[3] updates on the next edge; c returns to 0.
5. pad_din=0xFF, rstn pulled low mid-count -> all outputs 0 without a clock edge. After release -> gpioi_din=0xFF after 2+T edges; rise_pulse=0xFF exactly once.
6. irq_mask=0x0F, macro defined:
   - fall on bit 7 -> irq stays 0;
   - fall on bit 1 -> irq high one cycle.
   - Same stimulus with macro undefined -> irq, rise_pulse and fall_pulse remain 0.
